// File: rtl/fd_fetch_buffer_pkg.sv
// rtl/fd_fetch_buffer_pkg.sv - shared constants and fetch entry type for the fetch buffer
package fd_fetch_buffer_pkg;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_ADDR = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_NONE     = 5'd0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
  } fetch_entry_t;

endpackage

// File: rtl/fd_exc_check.sv
// rtl/fd_exc_check.sv - combinational fetch address check producing AdEL for bad PCs
module fd_exc_check
  import fd_fetch_buffer_pkg::*;
#(
  parameter logic [31:0] IM_BASE = PC_RESET_VAL,
  parameter logic [31:0] IM_LAST = IM_LAST_ADDR
) (
  input  logic [31:0] f_pc,
  output logic [4:0]  exccode
);

  // Misaligned or outside instruction memory raises AdEL.
  always_comb begin
    exccode = EXC_NONE;
    if ((f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_LAST)) begin
      exccode = EXC_ADEL;
    end
  end

endmodule

// File: rtl/fd_fetch_buffer.sv
// rtl/fd_fetch_buffer.sv - two-entry F/D fetch buffer with PC enable; FETCH_EXC_CHECK_EN adds AdEL tagging
module fd_fetch_buffer
  import fd_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH   = 2,
  parameter logic [31:0] IM_BASE = PC_RESET_VAL,
  parameter logic [31:0] IM_LAST = IM_LAST_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_valid,
  output logic        pc_en,
  input  logic        flush,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode
);

  // Only a two-entry buffer is built; catch other settings at elaboration.
  if (DEPTH != 2 || IM_BASE > IM_LAST) begin : g_bad_cfg
    $error("fd_fetch_buffer: DEPTH must be 2 and IM_BASE <= IM_LAST");
  end

  logic [1:0]   count_q, count_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];

  logic         push;
  logic         pop;
  logic [4:0]   new_exc;
  logic [31:0]  new_instr;
  fetch_entry_t head;

`ifdef FETCH_EXC_CHECK_EN
  fd_exc_check #(
    .IM_BASE (IM_BASE),
    .IM_LAST (IM_LAST)
  ) u_exc_check (
    .f_pc    (f_pc),
    .exccode (new_exc)
  );
  assign new_instr = (new_exc != EXC_NONE) ? 32'h0 : f_instr;
`else
  assign new_exc   = EXC_NONE;
  assign new_instr = f_instr;
`endif

  // Handshakes and head presentation; everything here derives from registered state.
  always_comb begin
    pc_en     = (count_q != 2'd2);
    d_valid   = (count_q != 2'd0);
    push      = f_valid & pc_en & ~flush;
    pop       = d_valid & d_ready;
    head      = mem_q[rd_ptr_q];
    d_pc      = d_valid ? head.pc      : 32'h0;
    d_instr   = d_valid ? head.instr   : 32'h0;
    d_exccode = d_valid ? head.exccode : EXC_NONE;
  end

  // Next-state: flush empties the buffer, otherwise push/pop move pointers and count.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: f_pc, instr: new_instr, exccode: new_exc};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
